monty_final_sub: RTL and testbench

Final correction and output buffering stage of the Montgomery modular multiplier. It sits directly downstream of the word-level reduction pipeline and receives that pipeline's output T, which lies in [0, 2q). It applies the conditional subtraction so that the result is in [0, q), where q = qH·2^R + 1. It then buffers results in a small FIFO with a valid/ready output, because the reduction pipeline cannot stall.

---
 rtl/monty_final_sub.sv | 97 +++++++++
 tb/tb_monty_final_sub.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/monty_final_sub.sv
// Final conditional subtraction (T mod q for T < 2q) followed by a small
// first-word fall-through FIFO that absorbs the non-stallable reduction pipeline.
module monty_final_sub #(
  parameter  int LOGQ  = 60,
  parameter  int R     = 17,
  parameter  int DEPTH = 4,
  localparam int LOGQH = LOGQ - R,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  input  logic             in_valid,
  input  logic [LOGQ-1:0]  T,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  out_data,
  output logic             afull,
  output logic             overflow,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH = CW'(DEPTH - 2);

  logic [LOGQ-1:0] q_in;
  logic [LOGQ:0]   d_in;
  logic            v1_q, b1_q;
  logic [LOGQ-1:0] t1_q, d1_q;

  // One extra bit so the borrow of T - q is visible even when q is near 2^LOGQ.
  assign q_in = {qH, {(R-1){1'b0}}, 1'b1};
  assign d_in = {1'b0, T} - {1'b0, q_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) v1_q <= 1'b0;
    else      v1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      t1_q <= T;
      b1_q <= d_in[LOGQ];
      d1_q <= d_in[LOGQ-1:0];
    end
  end

  logic [LOGQ-1:0] mem_q [DEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            push, pop;
  logic [LOGQ-1:0] res;

  assign res       = b1_q ? t1_q : d1_q;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign push      = v1_q & ((cnt_q < FULL) | pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (pop)  rd_d = rd_q + 1'b1;
    if (push) wr_d = wr_q + 1'b1;
    if (push & ~pop)      cnt_d = cnt_q + 1'b1;
    else if (pop & ~push) cnt_d = cnt_q - 1'b1;
    if (v1_q & ~push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= res;
  end

  assign out_data = out_valid ? mem_q[rd_q] : '0;
  assign afull    = (cnt_q >= AF_TH);
  assign overflow = ovf_q;
  assign count    = cnt_q;

endmodule

// File: tb/tb_monty_final_sub.sv
// Bench for monty_final_sub: queue-based reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_monty_final_sub;
  localparam int LOGQ = 60, R = 17, DEPTH = 4, LOGQH = LOGQ - R, CW = $clog2(DEPTH) + 1;

  logic             clk, rst;
  logic [LOGQH-1:0] qH;
  logic             in_valid, out_ready;
  logic [LOGQ-1:0]  T;
  logic             out_valid, afull, overflow;
  logic [LOGQ-1:0]  out_data;
  logic [CW-1:0]    count;

  monty_final_sub #(.LOGQ(LOGQ), .R(R), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .qH(qH), .in_valid(in_valid), .T(T),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .afull(afull), .overflow(overflow), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the arithmetic definition of q.
  function automatic logic [63:0] ref_res(input logic [63:0] t, input logic [63:0] qh);
    logic [63:0] q;
    q = (qh << R) + 64'd1;
    return (t >= q) ? ((t - q) & ((64'd1 << LOGQ) - 1)) : t;
  endfunction

  logic [63:0] m_q[$];
  logic        m_v1, m_ovf, m_pop;
  logic [63:0] m_r1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_v1  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_pop = (m_q.size() != 0) && out_ready;
      if (m_pop) void'(m_q.pop_front());
      if (m_v1) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_r1);
        else m_ovf = 1'b1;
      end
      m_v1 = in_valid;
      m_r1 = ref_res(64'(T), 64'(qH));
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("afull", 64'(afull), 64'(m_q.size() >= DEPTH - 2));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("out_data", 64'(out_data), (m_q.size() != 0) ? m_q[0] : 64'd0);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  int sent;
  logic [63:0] qv, rnd;
  logic [63:0] exp_heads [4];

  initial begin
    rst = 1'b1; qH = '0; in_valid = 1'b0; T = '0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #5;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_afull", 64'(afull), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_data", 64'(out_data), 0);
    @(negedge clk); rst = 1'b1;

    // Basic reduction with q = 131073, out_ready held high.
    out_ready = 1'b1; qH = 43'd1;
    step(); in_valid = 1'b1; T = 60'd131072;
    step(); T = 60'd131073; chk("t1_lat", 64'(out_valid), 0);
    step(); T = 60'd262145; chk("t1_r0", 64'(out_data), 131072);
    step(); in_valid = 1'b0; chk("t1_r1", 64'(out_data), 0); chk("t1_v1", 64'(out_valid), 1);
    step(); chk("t1_r2", 64'(out_data), 131072);
    step(); chk("t1_empty", 64'(out_valid), 0);

    // Borrow across the top bit: q = 2^60 - 2^17 + 1, T = 2^60 - 1.
    step(); in_valid = 1'b1; qH = {LOGQH{1'b1}}; T = {LOGQ{1'b1}};
    step(); in_valid = 1'b0;
    step(); chk("t2_res", 64'(out_data), 64'd131070); chk("t2_cnt", 64'(count), 1);
    step();

    // Full FIFO with simultaneous push and pop.
    out_ready = 1'b0; qH = 43'd1;
    for (int i = 1; i <= 4; i++) begin
      step(); in_valid = 1'b1; T = 60'(i * 100);
    end
    step(); in_valid = 1'b0;
    step(); chk("t4_full", 64'(count), 4);
    step(); in_valid = 1'b1; T = 60'd500;
    step(); in_valid = 1'b0; out_ready = 1'b1;
    step(); out_ready = 1'b0;
    chk("t4_cnt", 64'(count), 4); chk("t4_head", 64'(out_data), 200); chk("t4_ovf", 64'(overflow), 0);
    out_ready = 1'b1;
    repeat (6) step();
    chk("t4_drained", 64'(count), 0);

    // Random traffic respecting afull, random consumer stalls.
    sent = 0;
    for (int cyc = 0; cyc < 300 && sent < 16; cyc++) begin
      step();
      out_ready = 1'($urandom_range(0, 1));
      if (!afull) begin
        qv = 64'($urandom_range(1, 1000));
        rnd = {32'($urandom), 32'($urandom)};
        in_valid = 1'b1; qH = LOGQH'(qv);
        T = LOGQ'(rnd % (2 * ((qv << R) + 1)));
        sent++;
      end else in_valid = 1'b0;
    end
    chk("t5_sent", 64'(sent), 16);
    step(); in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && (m_q.size() != 0 || m_v1); cyc++) step();
    chk("t5_drain", 64'(m_q.size()), 0);
    chk("t5_ovf", 64'(overflow), 0);

    // Overflow: five inputs into a stalled FIFO.
    out_ready = 1'b0; qH = 43'd1;
    for (int i = 1; i <= 5; i++) begin
      step(); in_valid = 1'b1; T = 60'(i * 10);
    end
    step(); in_valid = 1'b0;
    step();
    chk("t3_cnt", 64'(count), 4); chk("t3_ovf", 64'(overflow), 1); chk("t3_afull", 64'(afull), 1);
    exp_heads[0] = 10; exp_heads[1] = 20; exp_heads[2] = 30; exp_heads[3] = 40;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_head", 64'(out_data), exp_heads[i]);
      step();
    end
    chk("t3_empty", 64'(out_valid), 0);
    chk("t3_sticky", 64'(overflow), 1);

    // Asynchronous reset mid-stream with count=3 and a result in flight.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(); in_valid = 1'b1; T = 60'(1000 + i);
    end
    step(); in_valid = 1'b0;
    chk("t6_pre", 64'(count), 3);
    #3 rst = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 0); chk("t6_cnt", 64'(count), 0);
    chk("t6_afull", 64'(afull), 0); chk("t6_ovf", 64'(overflow), 0);
    step(); rst = 1'b1; in_valid = 1'b1; T = 60'd2024;
    step(); in_valid = 1'b0; chk("t6_lat", 64'(out_valid), 0);
    step(); chk("t6_out", 64'(out_data), 2024); chk("t6_v", 64'(out_valid), 1);
    chk("t6_nodup", 64'(count), 1);
    out_ready = 1'b1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
